apb_regfile: RTL and testbench

Parametrised APB3 completer register file; next generation of the 4×8-bit APB register slave in the Tiny Tapeout top. Generalised in data width, register count and address width. Adds programmable wait states, `pslverr` on unmapped and read-only writes, and a hardware update port for status registers. Sits between the pin-level APB bridge and the design's control/status logic.

---
 rtl/apb_regfile_pkg.sv | 15 +
 rtl/apb_wait_ctr.sv | 30 +++
 rtl/apb_regfile.sv | 100 ++++++++++
 tb/tb_apb_regfile.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register file and related completers.
package apb_regfile_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam int WCNT_W = 4;

    function automatic logic addr_valid(input logic [31:0] paddr, input int num_regs);
        return paddr < 32'(num_regs);
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with a zero flag; counts APB wait states and saturates at zero.
module apb_wait_ctr
    import apb_regfile_pkg::*;
#(
    parameter int W = WCNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // A load takes priority over a decrement so a new setup always restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_regfile.sv
// Parametrised APB3 completer register file with wait states, error response and
// a hardware update port for status registers.
module apb_regfile
    import apb_regfile_pkg::*;
#(
    parameter int                    DATA_W      = 8,
    parameter int                    ADDR_W      = 3,
    parameter int                    NUM_REGS    = 4,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    output logic                         pready,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pslverr,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    state_t            state;
    logic              setup;
    logic              wait_zero;
    logic              in_range;
    logic              ro_hit;
    logic              err;
    logic              commit_wr;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] regs [NUM_REGS];

    assign setup = psel && !penable;

    apb_wait_ctr #(.W(WCNT_W)) u_wait_ctr (
        .clk      (pclk),
        .rst      (preset),
        .load     (setup),
        .load_val (WCNT_W'(WAIT_STATES)),
        .dec      ((state == ACCESS) && psel && penable),
        .zero     (wait_zero)
    );

    // A setup in either state (re)starts the access; dropping psel aborts it.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (setup) state <= ACCESS;
                ACCESS:  if (!psel || (penable && wait_zero)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decode by comparison rather than indexing so unmapped addresses never reach past the arrays.
    always_comb begin
        ro_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (paddr == ADDR_W'(i)) begin
                ro_hit = RO_MASK[i];
                rd_val = regs[i];
            end
        end
    end

    assign in_range  = addr_valid(32'(paddr), NUM_REGS);
    assign err       = !in_range || (pwrite && ro_hit);
    assign pready    = (state == ACCESS) && psel && penable && wait_zero;
    assign pslverr   = pready && err;
    assign prdata    = (pready && !pwrite && in_range) ? rd_val : '0;
    assign commit_wr = pready && pwrite && !err;

    // An APB write to a register beats a simultaneous hardware update of the same register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_wr && (paddr == ADDR_W'(i))) begin
                    regs[i] <= pwdata;
                end else if (hw_we[i]) begin
                    regs[i] <= hw_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: tb/tb_apb_regfile.sv
// Directed bench: one default instance and one with wait states plus a read-only register 3.
module tb_apb_regfile;

    logic        pclk;
    logic        preset;
    logic        psel0, psel1;
    logic        penable, pwrite;
    logic [2:0]  paddr;
    logic [7:0]  pwdata;
    logic [3:0]  hw_we0, hw_we1;
    logic [31:0] hw_wdata;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [7:0]  prdata0, prdata1;
    logic [31:0] reg_q0, reg_q1;

    int total = 0;
    int bad   = 0;

    apb_regfile u0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
        .hw_we(hw_we0), .hw_wdata(hw_wdata), .reg_q(reg_q0)
    );

    apb_regfile #(.WAIT_STATES(3), .RO_MASK(4'b1000)) u1 (
        .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready1), .prdata(prdata1), .pslverr(pslverr1),
        .hw_we(hw_we1), .hw_wdata(hw_wdata), .reg_q(reg_q1)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Runs one full transfer on the chosen instance and reports what was seen at pready.
    task automatic apb_xfer(input int inst, input logic wr, input logic [2:0] addr,
                            input logic [7:0] data, output logic got_err,
                            output logic [7:0] got_rdata, output int waits);
        logic done;
        @(negedge pclk);
        if (inst == 0) psel0 = 1'b1; else psel1 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0; done = 1'b0; got_err = 1'b0; got_rdata = '0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (((inst == 0) ? pready0 : pready1) === 1'b1) begin
                got_err   = (inst == 0) ? pslverr0 : pslverr1;
                got_rdata = (inst == 0) ? prdata0 : prdata1;
                done      = 1'b1;
            end else begin
                waits++;
            end
            @(negedge pclk);
        end
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("[TB] FAIL xfer_timeout inst=%0d addr=%0d got no pready want pready", inst, addr);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        #12;
        total += 4;
        if ({pready0, pslverr0, prdata0} !== 10'h0) begin
            bad++; $display("[TB] FAIL reset_bus0 got=%h want=0", {pready0, pslverr0, prdata0});
        end
        if ({pready1, pslverr1, prdata1} !== 10'h0) begin
            bad++; $display("[TB] FAIL reset_bus1 got=%h want=0", {pready1, pslverr1, prdata1});
        end
        if (reg_q0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_regq0 got=%h want=0", reg_q0); end
        if (reg_q1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_regq1 got=%h want=0", reg_q1); end
        @(negedge pclk);
        preset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [7:0] vals [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic e; logic [7:0] rd; int w;
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b1, 3'(i), vals[i], e, rd, w);
            total++;
            if ({e, w[3:0], rd} !== 13'h0) begin
                bad++; $display("[TB] FAIL write%0d err/waits/rdata got=%b/%0d/%h want=0/0/00", i, e, w, rd);
            end
        end
        total++;
        if (reg_q0 !== 32'hEFBEADDE) begin bad++; $display("[TB] FAIL regq_after_writes got=%h want=efbeadde", reg_q0); end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b0, 3'(i), 8'h00, e, rd, w);
            total++;
            if (rd !== vals[i] || e !== 1'b0 || w != 0) begin
                bad++; $display("[TB] FAIL read%0d rdata/err/waits got=%h/%b/%0d want=%h/0/0", i, rd, e, w, vals[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        logic e; logic [7:0] rd; int w;
        apb_xfer(1, 1'b1, 3'd1, 8'h5A, e, rd, w);
        total += 2;
        if (w != 3 || e !== 1'b0) begin bad++; $display("[TB] FAIL wait_write waits/err got=%0d/%b want=3/0", w, e); end
        if (reg_q1[15:8] !== 8'h5A) begin bad++; $display("[TB] FAIL wait_regq got=%h want=5a", reg_q1[15:8]); end
    endtask

    task automatic test_unmapped();
        logic e; logic [7:0] rd; int w;
        apb_xfer(0, 1'b1, 3'd6, 8'h55, e, rd, w);
        total += 2;
        if (e !== 1'b1) begin bad++; $display("[TB] FAIL unmapped_write_err got=%b want=1", e); end
        if (reg_q0 !== 32'hEFBEADDE) begin bad++; $display("[TB] FAIL unmapped_regq got=%h want=efbeadde", reg_q0); end
        apb_xfer(0, 1'b0, 3'd6, 8'h00, e, rd, w);
        total++;
        if (e !== 1'b1 || rd !== 8'h00) begin
            bad++; $display("[TB] FAIL unmapped_read err/rdata got=%b/%h want=1/00", e, rd);
        end
    endtask

    task automatic test_read_only();
        logic e; logic [7:0] rd; int w;
        @(negedge pclk);
        hw_we1 = 4'b1000; hw_wdata = 32'h77000000;
        @(negedge pclk);
        hw_we1 = 4'b0000;
        total++;
        if (reg_q1[31:24] !== 8'h77) begin bad++; $display("[TB] FAIL ro_hw_load got=%h want=77", reg_q1[31:24]); end
        apb_xfer(1, 1'b1, 3'd3, 8'h11, e, rd, w);
        total += 2;
        if (e !== 1'b1) begin bad++; $display("[TB] FAIL ro_write_err got=%b want=1", e); end
        if (reg_q1[31:24] !== 8'h77) begin bad++; $display("[TB] FAIL ro_kept got=%h want=77", reg_q1[31:24]); end
        apb_xfer(1, 1'b0, 3'd3, 8'h00, e, rd, w);
        total++;
        if (rd !== 8'h77 || e !== 1'b0) begin bad++; $display("[TB] FAIL ro_read rdata/err got=%h/%b want=77/0", rd, e); end
        apb_xfer(1, 1'b1, 3'd0, 8'h21, e, rd, w);
        total++;
        if (e !== 1'b0 || reg_q1[7:0] !== 8'h21) begin
            bad++; $display("[TB] FAIL rw_on_ro_inst err/reg got=%b/%h want=0/21", e, reg_q1[7:0]);
        end
    endtask

    task automatic test_collision();
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h33;
        @(negedge pclk);
        penable = 1'b1; hw_we0 = 4'b0100; hw_wdata = 32'h00990000;
        #1;
        total++;
        if (pready0 !== 1'b1) begin bad++; $display("[TB] FAIL collision_pready got=%b want=1", pready0); end
        @(negedge pclk);
        psel0 = 1'b0; penable = 1'b0; hw_we0 = 4'b0000;
        total++;
        if (reg_q0[23:16] !== 8'h33) begin bad++; $display("[TB] FAIL collision_winner got=%h want=33", reg_q0[23:16]); end
        hw_we0 = 4'b0010; hw_wdata = 32'h00004200;
        @(negedge pclk);
        hw_we0 = 4'b0000;
        total++;
        if (reg_q0 !== 32'hEF3342DE) begin bad++; $display("[TB] FAIL hw_update got=%h want=ef3342de", reg_q0); end
    endtask

    task automatic test_abort();
        @(negedge pclk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'hC3;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        total++;
        if (pready1 !== 1'b0) begin bad++; $display("[TB] FAIL abort_wait_pready got=%b want=0", pready1); end
        @(negedge pclk);
        psel1 = 1'b0;
        @(negedge pclk);
        penable = 1'b0;
        @(negedge pclk);
        total++;
        if (reg_q1 !== 32'h77005A21) begin bad++; $display("[TB] FAIL abort_no_write got=%h want=77005a21", reg_q1); end
        // penable without a preceding setup must never start a transfer
        psel1 = 1'b1; penable = 1'b1;
        repeat (6) @(negedge pclk);
        #1;
        total += 2;
        if (pready1 !== 1'b0) begin bad++; $display("[TB] FAIL idle_penable_pready got=%b want=0", pready1); end
        if (reg_q1 !== 32'h77005A21) begin bad++; $display("[TB] FAIL idle_penable_write got=%h want=77005a21", reg_q1); end
        @(negedge pclk);
        psel1 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic e; logic [7:0] rd; int w;
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd2;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        total++;
        if (pready0 !== 1'b1 || prdata0 !== 8'h33) begin
            bad++; $display("[TB] FAIL pre_reset_read pready/rdata got=%b/%h want=1/33", pready0, prdata0);
        end
        #1 preset = 1'b1;
        #1;
        total += 2;
        if ({pready0, pslverr0, prdata0} !== 10'h0) begin
            bad++; $display("[TB] FAIL midreset_bus got=%h want=0", {pready0, pslverr0, prdata0});
        end
        if (reg_q0 !== 32'h0 || reg_q1 !== 32'h0) begin
            bad++; $display("[TB] FAIL midreset_regq got=%h/%h want=0/0", reg_q0, reg_q1);
        end
        @(negedge pclk);
        preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
        apb_xfer(1, 1'b1, 3'd0, 8'h12, e, rd, w);
        total++;
        if (w != 3 || e !== 1'b0 || reg_q1 !== 32'h00000012) begin
            bad++; $display("[TB] FAIL post_reset_write waits/err/reg got=%0d/%b/%h want=3/0/00000012", w, e, reg_q1);
        end
        apb_xfer(0, 1'b0, 3'd2, 8'h00, e, rd, w);
        total++;
        if (rd !== 8'h00 || e !== 1'b0 || w != 0) begin
            bad++; $display("[TB] FAIL post_reset_read rdata/err/waits got=%h/%b/%0d want=00/0/0", rd, e, w);
        end
    endtask

    initial begin
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; hw_we0 = '0; hw_we1 = '0; hw_wdata = '0;
        preset = 1'b0;
        test_reset();
        test_write_read();
        test_wait_states();
        test_unmapped();
        test_read_only();
        test_collision();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
